// File: rtl/button_debouncer_array.sv
// button_debouncer_array: per-channel synchroniser, stability filter, press/release/long-press pulses
module button_debouncer_array #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG} state_t;
  logic [CHANNELS-1:0] s1, s2;
  always_ff @(posedge clk) begin
    s1 <= rst ? '0 : button ^ {CHANNELS{ACTIVE_LOW}};
    s2 <= rst ? '0 : s1;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          deb, prs, rls, lng, flip, hit;
    assign flip = (s2[c] != deb) && (cnt == CW'(STABLE_CYCLES - 1));
    // a release landing on the threshold edge wins over the long press
    assign hit  = (state == PRESSED) && (hcnt == HW'(LONG_CYCLES - 2)) && !flip;
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= RELEASED;
        cnt   <= '0;
        hcnt  <= '0;
        deb   <= 1'b0;
        prs   <= 1'b0;
        rls   <= 1'b0;
        lng   <= 1'b0;
      end else begin
        cnt   <= (s2[c] == deb || flip) ? '0 : cnt + 1'b1;
        deb   <= flip ? s2[c] : deb;
        prs   <= flip && s2[c];
        rls   <= flip && !s2[c];
        lng   <= hit;
        hcnt  <= !deb ? '0 : (hcnt == HW'(LONG_CYCLES - 1)) ? hcnt : hcnt + 1'b1;
        state <= flip ? (s2[c] ? PRESSED : RELEASED) : hit ? LONG : state;
      end
    end
    assign debounced[c]     = deb;
    assign press[c]         = prs;
    assign release_pulse[c] = rls;
    assign long_press[c]    = lng;
  end
endmodule

// File: tb/tb_button_debouncer_array.sv
// tb_button_debouncer_array: directed stimulus with a timed scoreboard of expected output words
module tb_button_debouncer_array;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] b   = 4'h0;
  logic [3:0] bl  = 4'hF;
  logic [3:0] dh, ph, rh, lh, dl, pl, rl, ll;
  int         e = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         at;
    string      tag;
    bit         lo;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];

  button_debouncer_array #(.CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .button(b),
    .debounced(dh), .press(ph), .release_pulse(rh), .long_press(lh)
  );
  button_debouncer_array #(.CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .button(bl),
    .debounced(dl), .press(pl), .release_pulse(rl), .long_press(ll)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  function automatic void expect_at(int at, string tag, bit lo,
                                    logic [3:0] d, logic [3:0] p, logic [3:0] r, logic [3:0] l);
    exp_t x;
    x.at  = at;
    x.tag = tag;
    x.lo  = lo;
    x.v   = {d, p, r, l};
    q.push_back(x);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == e) begin
        logic [15:0] obs;
        obs = q[i].lo ? {dl, pl, rl, ll} : {dh, ph, rh, lh};
        checks++;
        assert (obs === q[i].v) else begin
          errors++;
          $error("FAIL %s edge=%0d dut=%s observed={deb,prs,rel,lng}=%h expected=%h",
                 q[i].tag, e, q[i].lo ? "lo" : "hi", obs, q[i].v);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int k = 1; k <= 2; k++) begin
      expect_at(k, "reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      expect_at(k, "reset", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(2);
    rst = 1'b0;
    t = e;
    for (int k = 1; k <= 50; k++) begin
      expect_at(t + k, "idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      expect_at(t + k, "idle_lo", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(50);
    // clean press on ch0, released before the long threshold
    t = e;
    for (int k = 1; k <= 16; k++)
      expect_at(t + k, "clean", 1'b0, {3'b0, k >= 6 && k <= 12}, {3'b0, k == 6}, {3'b0, k == 13}, 4'h0);
    b = 4'b0001;
    tick(7);
    b = 4'b0000;
    tick(9);
    // 3-sample glitch on ch1 is rejected
    t = e;
    for (int k = 1; k <= 12; k++)
      expect_at(t + k, "glitch", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    b = 4'b0010;
    tick(3);
    b = 4'b0000;
    tick(9);
    // 3 high, 1 low restarts the count; then a full run flips the level
    t = e;
    for (int k = 1; k <= 20; k++)
      expect_at(t + k, "restart", 1'b0, {2'b0, k >= 10 && k <= 16, 1'b0}, {2'b0, k == 10, 1'b0},
                {2'b0, k == 17, 1'b0}, 4'h0);
    b = 4'b0010;
    tick(3);
    b = 4'b0000;
    tick(1);
    b = 4'b0010;
    tick(7);
    b = 4'b0000;
    tick(9);
    // long press on ch2 fires once while held
    t = e;
    for (int k = 1; k <= 40; k++)
      expect_at(t + k, "long", 1'b0, {1'b0, k >= 6 && k <= 35, 2'b0}, {1'b0, k == 6, 2'b0},
                {1'b0, k == 36, 2'b0}, {1'b0, k == 15, 2'b0});
    b = 4'b0100;
    tick(30);
    b = 4'b0000;
    tick(10);
    // short second press on ch2: no long press
    t = e;
    for (int k = 1; k <= 18; k++)
      expect_at(t + k, "short", 1'b0, {1'b0, k >= 6 && k <= 13, 2'b0}, {1'b0, k == 6, 2'b0},
                {1'b0, k == 14, 2'b0}, 4'h0);
    b = 4'b0100;
    tick(8);
    b = 4'b0000;
    tick(10);
    // reset while ch0 pressed and ch3 mid-count
    t = e;
    for (int k = 1; k <= 30; k++)
      expect_at(t + k, "midreset", 1'b0,
                {k >= 19 && k <= 25, 2'b0, (k >= 6 && k <= 12) || (k >= 19 && k <= 25)},
                {k == 19, 2'b0, k == 6 || k == 19}, {k == 26, 2'b0, k == 26}, 4'h0);
    b = 4'b0001;
    tick(8);
    b = 4'b1001;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(7);
    b = 4'b0000;
    tick(10);
    // active-low instance: simultaneous presses on ch0 and ch1
    t = e;
    for (int k = 1; k <= 15; k++) begin
      expect_at(t + k, "active_low", 1'b1, (k >= 6 && k <= 12) ? 4'b0011 : 4'b0000,
                (k == 6) ? 4'b0011 : 4'b0000, (k == 13) ? 4'b0011 : 4'b0000, 4'h0);
      expect_at(t + k, "hi_quiet", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    bl = 4'b1100;
    tick(7);
    bl = 4'b1111;
    tick(8);
    tick(3);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
